// File: rtl/divider_unit.sv
// Unsigned restoring divider: N RUN cycles after an accepted start, done pulses in cycle N+1 (cycle 1 for b == 0).
// A start is taken only when not busy; start, a and b are ignored while an iteration runs.
module divider_unit #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   rem_q, rem_d;
   logic [N-1:0]   dvd_q, dvd_d;
   logic [N-1:0]   dvs_q, dvs_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   quotient_q, quotient_d;
   logic [N-1:0]   remainder_q, remainder_d;
   logic           div_by_zero_q, div_by_zero_d;

   logic [N:0]     rem_sh;
   logic [N:0]     trial;
   logic [N-1:0]   rem_next;
   logic [N-1:0]   dvd_next;

   // rem_q < divisor always holds, so trial fits N+1 signed bits and trial[N] is its sign.
   always_comb begin
      rem_sh   = {rem_q, dvd_q[N-1]};
      trial    = rem_sh - {1'b0, dvs_q};
      rem_next = trial[N] ? rem_sh[N-1:0] : trial[N-1:0];
      dvd_next = {dvd_q[N-2:0], ~trial[N]};
   end

   always_comb begin
      state_d       = state_q;
      rem_d         = rem_q;
      dvd_d         = dvd_q;
      dvs_d         = dvs_q;
      cnt_d         = cnt_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      div_by_zero_d = div_by_zero_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               if (b == '0) begin
                  state_d       = DONE;
                  quotient_d    = '1;
                  remainder_d   = a;
                  div_by_zero_d = 1'b1;
               end else begin
                  state_d = RUN;
                  rem_d   = '0;
                  dvd_d   = a;
                  dvs_d   = b;
                  cnt_d   = CW'(N);
               end
            end
         end
         RUN: begin
            rem_d = rem_next;
            dvd_d = dvd_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d       = DONE;
               quotient_d    = dvd_next;
               remainder_d   = rem_next;
               div_by_zero_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         rem_q         <= '0;
         dvd_q         <= '0;
         dvs_q         <= '0;
         cnt_q         <= '0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rem_q         <= rem_d;
         dvd_q         <= dvd_d;
         dvs_q         <= dvs_d;
         cnt_q         <= cnt_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_divider_unit.sv
// Bench for divider_unit: directed cases plus all 256 operand pairs in shuffled order vs an arithmetic model.
module tb_divider_unit;

   localparam int N    = 4;
   localparam int MAXV = (1 << N) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   int vectors     = 0;
   int miscompares = 0;
   int exp_q       = 0;
   int exp_r       = 0;
   int exp_dbz     = 0;

   divider_unit #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      if (obs != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_results(input string tag);
      check({tag, ".quotient"}, int'(quotient), exp_q);
      check({tag, ".remainder"}, int'(remainder), exp_r);
      check({tag, ".div_by_zero"}, int'(div_by_zero), exp_dbz);
   endtask

   // Entered #1 after a rising edge (cycle 0); returns #1 after the edge opening the done cycle.
   task automatic run_op(input int av, input int bv, input bit junk);
      bit z;
      int q, r, lat;
      z   = (bv == 0);
      q   = z ? MAXV : av / bv;
      r   = z ? av : av % bv;
      lat = z ? 1 : N + 1;
      start = 1'b1;
      a     = N'(av);
      b     = N'(bv);
      for (int cyc = 1; cyc <= lat; cyc++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         a     = N'($urandom_range(0, MAXV));
         b     = N'($urandom_range(0, MAXV));
         check("busy", int'(busy), int'(!z && cyc <= N));
         check("done", int'(done), int'(cyc == lat));
         if (cyc == lat) begin
            exp_q   = q;
            exp_r   = r;
            exp_dbz = int'(z);
         end
         check_results("out");
         if (junk && cyc < lat) begin
            start = (cyc == 2) || ($urandom_range(0, 1) == 1);
            if (cyc == 2) begin
               a = N'(6);
               b = N'(2);
            end
         end
      end
      if (!z) begin
         check("identity", int'(quotient) * bv + int'(remainder), av);
         check("rem_lt_b", int'(int'(remainder) < bv), 1);
      end
   endtask

   task automatic idle_cycle();
      start = 1'b0;
      @(posedge clk);
      #1;
      check("idle.busy", int'(busy), 0);
      check("idle.done", int'(done), 0);
      check_results("idle");
   endtask

   int pairs[256];

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      @(posedge clk);
      #1;
      check("rst.busy", int'(busy), 0);
      check("rst.done", int'(done), 0);
      check_results("rst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op(13, 3, 1'b0);
      idle_cycle();
      run_op(15, 1, 1'b0);
      run_op(2, 7, 1'b0);
      run_op(0, 5, 1'b0);
      idle_cycle();
      run_op(9, 0, 1'b0);
      run_op(8, 2, 1'b0);
      idle_cycle();

      // Stray start in cycle 2 must be ignored; a start in DONE chains straight on.
      run_op(13, 3, 1'b1);
      run_op(7, 2, 1'b0);
      idle_cycle();

      // Reset in cycle 3 of 13/3 aborts the operation.
      start = 1'b1;
      a     = N'(13);
      b     = N'(3);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      exp_q   = 0;
      exp_r   = 0;
      exp_dbz = 0;
      check("abort.busy", int'(busy), 0);
      check("abort.done", int'(done), 0);
      check_results("abort");
      @(negedge clk);
      rst = 1'b0;
      repeat (N + 2) idle_cycle();
      run_op(10, 4, 1'b0);
      idle_cycle();

      for (int i = 0; i < 256; i++) pairs[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j, t;
         j        = $urandom_range(0, i);
         t        = pairs[i];
         pairs[i] = pairs[j];
         pairs[j] = t;
      end
      for (int i = 0; i < 256; i++) begin
         run_op(pairs[i] >> 4, pairs[i] & 15, $urandom_range(0, 3) == 0);
         repeat ($urandom_range(0, 2)) idle_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
